// File: rtl/seq_divu.sv
// Sequential unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define DIVU_FAST_PATH_EN to finish divide-by-zero and dividend<divisor in the accept cycle.
module seq_divu #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [W-1:0]  d_reg;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  r_reg;
  logic [CW-1:0] count;
  logic          dbz;

  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic          fast_path;

  // The partial remainder always stays below 2^W (below D, or below 2^W when D=0),
  // so W bits hold it and the top bit of the W+1-bit trial difference is its sign.
  assign shifted = {r_reg, q_reg[W-1]};
  assign trial   = shifted - {1'b0, d_reg};

`ifdef DIVU_FAST_PATH_EN
  assign fast_path = (divisor == '0) || (dividend < divisor);
`else
  assign fast_path = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      d_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            in_ready <= 1'b0;
            d_reg    <= divisor;
            dbz      <= (divisor == '0);
            count    <= CW'(W);
            if (fast_path) begin
              q_reg     <= (divisor == '0) ? '1 : '0;
              r_reg     <= dividend;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              q_reg <= dividend;
              r_reg <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!trial[W]) begin
            r_reg <= trial[W-1:0];
            q_reg <= {q_reg[W-2:0], 1'b1};
          end else begin
            r_reg <= shifted[W-1:0];
            q_reg <= {q_reg[W-2:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz;

endmodule
